window_linebuffer: RTL

- Streaming sliding-window generator that sits directly upstream of the per-class inner-product stages.
- Accepts one 7-bit grayscale pixel per cycle in raster order and keeps WIN_ROWS-1 full image lines in line buffers.
- Presents a registered WIN_ROWS x WIN_COLS patch as an 81-slot feature array (slot 0 = bias slot), plus a valid strobe and the patch position.
- The feature array fans out unchanged to every classifier instance.

---
 rtl/window_linebuffer_pkg.sv | 18 +
 rtl/window_linebuffer_line_delay.sv | 36 +++
 rtl/window_linebuffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/window_linebuffer_pkg.sv
// Shared types and window geometry for the sliding-window generator.
package window_linebuffer_pkg;

   localparam int unsigned PIX_W    = 7;
   localparam int unsigned WIN_ROWS = 8;
   localparam int unsigned WIN_COLS = 10;
   localparam int unsigned FEAT_N   = 81;
   localparam int unsigned CNT_W    = 5;

   typedef logic [PIX_W-1:0]   pixel_t;
   typedef pixel_t [FEAT_N-1:0] feat_array_t;

   // Feature slot of window pixel (r,c); slot 0 is the bias slot.
   function automatic int unsigned feat_idx(input int unsigned r, input int unsigned c);
      return 1 + r * WIN_COLS + c;
   endfunction

endpackage

// File: rtl/window_linebuffer_line_delay.sv
// One image line of delay: output is the pixel accepted DEPTH enables earlier.
module window_linebuffer_line_delay
   import window_linebuffer_pkg::*;
#(
   parameter int unsigned DEPTH = 28
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   input  pixel_t din,
   output pixel_t dout
);

   pixel_t [DEPTH-1:0] mem_q;
   pixel_t [DEPTH-1:0] mem_d;

   // Shift one position per accepted pixel.
   always_comb begin
      mem_d = mem_q;
      if (en) begin
         mem_d = {mem_q[DEPTH-2:0], din};
      end
   end

   // Delay-line storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/window_linebuffer.sv
// Streaming WIN_ROWS x WIN_COLS sliding-window generator over a raster pixel stream.
module window_linebuffer
   import window_linebuffer_pkg::*;
#(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  pixel_t           pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output feat_array_t      xarray,
   output logic             win_valid,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col
);

   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] cur_col_c, cur_row_c;
   logic             win_valid_q, win_valid_d;
   logic [CNT_W-1:0] win_row_q, win_row_d;
   logic [CNT_W-1:0] win_col_q, win_col_d;

   pixel_t [WIN_ROWS-1:0][WIN_COLS-1:0] win_q, win_d;

   // tap[k] = same column, k lines earlier; tap[0] is the live pixel.
   pixel_t tap [WIN_ROWS];

   assign tap[0] = pix_in;

   for (genvar k = 0; k < WIN_ROWS - 1; k++) begin : g_delay
      window_linebuffer_line_delay #(
         .DEPTH (IMG_W)
      ) u_delay (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (pix_valid),
         .din   (tap[k]),
         .dout  (tap[k+1])
      );
   end

   // Position of the incoming pixel; sof forces it to (0,0).
   always_comb begin
      cur_col_c = sof ? '0 : col_q;
      cur_row_c = sof ? '0 : row_q;
   end

   // Raster counters and window-valid decision.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_valid_d = 1'b0;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      if (pix_valid) begin
         if (cur_col_c == CNT_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row_c == CNT_W'(IMG_H - 1)) ? '0 : cur_row_c + CNT_W'(1);
         end else begin
            col_d = cur_col_c + CNT_W'(1);
            row_d = cur_row_c;
         end
         if ((cur_row_c >= CNT_W'(WIN_ROWS - 1)) && (cur_col_c >= CNT_W'(WIN_COLS - 1))) begin
            win_valid_d = 1'b1;
            win_row_d   = cur_row_c - CNT_W'(WIN_ROWS - 1);
            win_col_d   = cur_col_c - CNT_W'(WIN_COLS - 1);
         end
      end
   end

   // Window shift: rows move left, new right column comes from the line taps.
   always_comb begin
      win_d = win_q;
      if (pix_valid) begin
         for (int unsigned r = 0; r < WIN_ROWS; r++) begin
            for (int unsigned c = 0; c < WIN_COLS - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIN_COLS-1] = tap[WIN_ROWS-1-r];
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         win_q       <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         win_q       <= win_d;
      end
   end

   // Flatten the window registers into the feature array; bias slot stays 0.
   always_comb begin
      xarray = '0;
      for (int unsigned r = 0; r < WIN_ROWS; r++) begin
         for (int unsigned c = 0; c < WIN_COLS; c++) begin
            xarray[feat_idx(r, c)] = win_q[r][c];
         end
      end
   end

   assign win_valid = win_valid_q;
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;

endmodule
